// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the multicycle CPU datapath.
//   fetch_state_t : state encoding of the instruction-fetch FSM
//   INSTR_BYTES   : size of one instruction in bytes (sequential PC step)
//   RESET_PC      : PC value after reset, shared with the PC register
package cpu_pkg;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_DONE = 3'd3,
        FS_ERR  = 3'd4
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch reader for the multicycle CPU.
//
// Fetches one instruction word per fetch_start request. It latches the PC,
// issues a req/gnt read to instruction memory and waits for rvalid. It then
// loads the IR and produces a one-cycle PC write-enable carrying PC+4.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   fetch_start  start one fetch (only looked at in IDLE)
//   pc           current PC register value
//   imem_req     read request to instruction memory (held until imem_gnt)
//   imem_addr    read address, the PC latched at fetch_start
//   imem_gnt     memory accepted the request
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   ir           instruction register, holds its value between fetches
//   ir_valid     one-cycle pulse when ir is updated
//   npc          latched fetch address + 4
//   pc_we        one-cycle PC write-enable
//   pc_next      value for the PC to load (equals npc)
//   busy         high whenever the FSM is not idle
//   fetch_err    sticky error: misaligned PC, or rvalid timeout
//
// Configuration macro:
//   FETCH_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT cycles
//                     without rvalid and goes to ERR. When undefined, WAIT
//                     waits indefinitely.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] npc,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_next,
    output logic              busy,
    output logic              fetch_err
);

    fetch_state_t state_reg;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] wait_cnt_reg;
`else
    // TIMEOUT is only meaningful with the timeout counter built in.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= FS_IDLE;
            imem_req     <= 1'b0;
            imem_addr    <= ADDR_W'(RESET_PC);
            ir           <= '0;
            ir_valid     <= 1'b0;
            npc          <= ADDR_W'(RESET_PC);
            pc_we        <= 1'b0;
            pc_next      <= ADDR_W'(RESET_PC);
            busy         <= 1'b0;
            fetch_err    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            // Pulse outputs are high only in the DONE cycle.
            ir_valid <= 1'b0;
            pc_we    <= 1'b0;

            case (state_reg)
                FS_IDLE: begin
                    if (fetch_start) begin
                        busy <= 1'b1;
                        if (pc[1:0] == 2'b00) begin
                            imem_addr <= pc;
                            npc       <= pc + ADDR_W'(INSTR_BYTES);
                            imem_req  <= 1'b1;
                            state_reg <= FS_REQ;
                        end else begin
                            // Misaligned: never touch memory, lock up in ERR.
                            fetch_err <= 1'b1;
                            state_reg <= FS_ERR;
                        end
                    end
                end

                FS_REQ: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        if (imem_rvalid) begin
                            // Zero-latency memory: data arrives with the grant.
                            ir        <= imem_rdata;
                            ir_valid  <= 1'b1;
                            pc_we     <= 1'b1;
                            pc_next   <= npc;
                            state_reg <= FS_DONE;
                        end else begin
                            state_reg <= FS_WAIT;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt_reg <= '0;
`endif
                        end
                    end
                end

                FS_WAIT: begin
                    if (imem_rvalid) begin
                        ir        <= imem_rdata;
                        ir_valid  <= 1'b1;
                        pc_we     <= 1'b1;
                        pc_next   <= npc;
                        state_reg <= FS_DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // The counter holds the number of completed WAIT cycles,
                    // so the TIMEOUT-th empty WAIT cycle triggers the error.
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        state_reg <= FS_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end

                FS_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= FS_IDLE;
                end

                FS_ERR: begin
                    state_reg <= FS_ERR;
                end

                default: begin
                    imem_req  <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] npc;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        busy;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_ir;   // what the IR should currently hold

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .npc         (npc),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply reset part-way through a cycle and check that all outputs clear
    // right away, before any clock edge.
    task automatic test_reset(input string tag);
        logic [31:0] all_out;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        all_out = {31'b0, imem_req} | imem_addr | ir | {31'b0, ir_valid} | npc |
                  {31'b0, pc_we} | pc_next | {30'b0, busy, fetch_err};
        n_cmp++;
        if (all_out !== 32'h0) begin
            n_bad++;
            $display("FAIL %s async reset outputs got %h want 00000000", tag, all_out);
        end
        model_ir = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ir !== 32'h0 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after reset busy=%b ir=%h err=%b want 0 0 0", tag, busy, ir, fetch_err);
        end
    endtask

    // One aligned fetch. The grant comes g cycles after the first REQ cycle,
    // and rvalid r cycles after the grant. Expected timing:
    //   cycle k (after the k-th edge past start): req high for k <= 1+g;
    //   DONE at k = 2+g+r; idle again at k = 3+g+r.
    // With noise set, the task injects spurious rvalid before the grant,
    // changes the pc mid-fetch and raises fetch_start during DONE.
    task automatic run_fetch(input logic [31:0] pcv, input int g, input int r,
                             input logic [31:0] data, input bit noise, input string tag);
        int          done_k;
        logic [31:0] exp_npc;
        int          we_count;
        done_k   = 2 + g + r;
        exp_npc  = pcv + 32'd4;
        we_count = 0;
        @(posedge clk);
        #1;
        fetch_start = 1'b1;
        pc          = pcv;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            @(posedge clk);
            #1;
            fetch_start = (noise && k == done_k) ? 1'b1 : 1'b0;
            if (noise) pc = $urandom;
            imem_gnt    = (k == 1 + g);
            imem_rvalid = (k == 1 + g + r) || (noise && k < 1 + g && $urandom_range(0, 1) == 1);
            imem_rdata  = (k == 1 + g + r) ? data : $urandom;
            @(negedge clk);
            if (k >= done_k) model_ir = data;
            n_cmp++;
            if (imem_req !== (k <= 1 + g)) begin
                n_bad++;
                $display("FAIL %s k=%0d imem_req got %b want %b", tag, k, imem_req, (k <= 1 + g));
            end
            if (k <= 1 + g) begin
                n_cmp++;
                if (imem_addr !== pcv) begin
                    n_bad++;
                    $display("FAIL %s k=%0d imem_addr got %h want %h", tag, k, imem_addr, pcv);
                end
            end
            n_cmp++;
            if (ir_valid !== (k == done_k) || pc_we !== (k == done_k)) begin
                n_bad++;
                $display("FAIL %s k=%0d ir_valid/pc_we got %b/%b want %b", tag, k, ir_valid, pc_we, (k == done_k));
            end
            if (pc_we === 1'b1) we_count++;
            n_cmp++;
            if (ir !== model_ir) begin
                n_bad++;
                $display("FAIL %s k=%0d ir got %h want %h", tag, k, ir, model_ir);
            end
            n_cmp++;
            if (busy !== (k <= done_k)) begin
                n_bad++;
                $display("FAIL %s k=%0d busy got %b want %b", tag, k, busy, (k <= done_k));
            end
            if (k == done_k) begin
                n_cmp++;
                if (pc_next !== exp_npc || npc !== exp_npc) begin
                    n_bad++;
                    $display("FAIL %s pc_next/npc got %h/%h want %h", tag, pc_next, npc, exp_npc);
                end
            end
        end
        n_cmp++;
        if (we_count != 1 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s pc_we pulses got %0d err=%b want 1 err=0", tag, we_count, fetch_err);
        end
        fetch_start = 1'b0;
    endtask

    task automatic test_zero_latency();
        run_fetch(32'h0000_0010, 0, 0, 32'h00A0_0093, 1'b0, "zero_latency");
    endtask

    task automatic test_delayed();
        run_fetch(32'h0000_0100, 2, 2, 32'hDEAD_BEEF, 1'b0, "delayed");
    endtask

    task automatic test_wrap();
        run_fetch(32'hFFFF_FFFC, 1, 1, 32'h1234_5678, 1'b0, "wrap");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            run_fetch({$urandom, 2'b00} & 32'hFFFF_FFFC, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), $urandom, 1'b1, "random");
        end
    endtask

    task automatic test_misaligned();
        @(posedge clk);
        #1;
        fetch_start = 1'b1;
        pc          = 32'h0000_0006;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            fetch_start = 1'($urandom_range(0, 1));
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b0 || fetch_err !== 1'b1 || busy !== 1'b1 ||
                pc_we !== 1'b0 || ir_valid !== 1'b0 || ir !== model_ir) begin
                n_bad++;
                $display("FAIL misaligned k=%0d req=%b err=%b busy=%b we=%b irv=%b ir=%h want 0 1 1 0 0 %h",
                         k, imem_req, fetch_err, busy, pc_we, ir_valid, ir, model_ir);
            end
        end
        fetch_start = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        test_reset("misaligned_reset");
    endtask

    // Reset lands while waiting for rvalid; the late response must be dropped.
    task automatic test_reset_mid_fetch();
        @(posedge clk);
        #1;
        fetch_start = 1'b1;
        pc          = 32'h0000_0040;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        @(posedge clk);
        #1;
        imem_gnt = 1'b0;
        test_reset("reset_mid_fetch");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ir !== 32'h0 || ir_valid !== 1'b0 || pc_we !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_fetch late rvalid ir=%h irv=%b we=%b busy=%b want 0 0 0 0",
                         ir, ir_valid, pc_we, busy);
            end
        end
        imem_rvalid = 1'b0;
    endtask

    // Grant without any rvalid. With the timeout built in, the error appears
    // after 16 WAIT cycles: WAIT occupies k=2..17 and ERR is visible at k=18.
    task automatic test_timeout();
        bit   exp_err;
        @(posedge clk);
        #1;
        fetch_start = 1'b1;
        pc          = 32'h0000_0200;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        imem_gnt    = 1'b1;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk);
            #1;
            imem_gnt = 1'b0;
            @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
            exp_err = (k >= 18);
`else
            exp_err = 1'b0;
`endif
            n_cmp++;
            if (fetch_err !== exp_err || busy !== 1'b1 || imem_req !== 1'b0 || pc_we !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout k=%0d err=%b busy=%b req=%b we=%b want %b 1 0 0",
                         k, fetch_err, busy, imem_req, pc_we, exp_err);
            end
        end
        test_reset("timeout_reset");
    endtask

    initial begin
        rst         = 1'b0;
        fetch_start = 1'b0;
        pc          = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        model_ir    = 32'h0;
        #12;
        test_reset("power_on");
        test_zero_latency();
        test_delayed();
        test_wrap();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_fetch();
        test_timeout();
        test_zero_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch reader for the multicycle CPU: consumes the current PC value, issues one read per fetch to instruction memory over a req/gnt + rvalid handshake, and latches the returned word into the instruction register (IR).
- Produces the sequential next PC (pc+4) plus a one-cycle PC write-enable and next-PC value, which the PC register loads.
- Sits between the PC register, the main control FSM and instruction memory.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- DATA_W, 32, instruction width in bits.
- TIMEOUT, 16, maximum cycles waiting for rvalid after grant (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- fetch_start  in  1  control FSM requests one fetch; sampled only in IDLE.
- pc  in  ADDR_W  current PC register output.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address; equals pc latched at fetch_start.
- imem_gnt  in  1  memory accepted request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_W  read data.
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  one-cycle pulse when ir is updated.
- npc  out  ADDR_W  latched fetch address + 4.
- pc_we  out  1  one-cycle PC write-enable.
- pc_next  out  ADDR_W  value for the PC to load; equals npc.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  sticky error flag: misaligned fetch address, or timeout when FETCH_TIMEOUT_EN is defined.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; imem_req=0, imem_addr=0, ir=0, ir_valid=0, npc=0, pc_we=0, pc_next=0, busy=0, fetch_err=0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - fetch_start=1 and pc[1:0]==0: latch imem_addr<=pc and npc<=pc+4 (mod 2^ADDR_W, wraps silently), then go to REQ.
  - fetch_start=1 and pc[1:0]!=0: fetch_err<=1, go to ERR; no memory request is issued.
- REQ:
  - imem_req=1 and imem_addr held stable until imem_gnt=1.
  - gnt=1 with rvalid=0 in the same cycle: go to WAIT.
  - gnt=1 and rvalid=1 in the same cycle (zero-latency memory): capture rdata, go to DONE.
- WAIT:
  - imem_req=0.
  - rvalid=1: ir<=rdata, go to DONE.
  - rvalid while in IDLE, REQ-before-gnt, DONE or ERR is ignored.
- DONE, exactly one cycle:
  - ir_valid=1, pc_we=1, pc_next=npc.
  - Next state is IDLE.
  - fetch_start asserted in DONE is ignored. Control must re-assert it in IDLE.
- ERR: holds until reset. busy=1, pc_we never asserted, ir unchanged.
- Latency with gnt and rvalid both in the first REQ cycle: fetch_start at cycle 0 → REQ at 1 → DONE (ir_valid, pc_we) at 2. Each cycle of gnt or rvalid delay adds one cycle.
- ir holds its value between fetches. pc is not sampled outside IDLE, so PC changes mid-fetch do not affect the fetch.
- Reset asserted mid-fetch returns to IDLE immediately. Any outstanding memory response is then dropped (ignored, since state is IDLE).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each cycle in WAIT. If it reaches TIMEOUT without rvalid, set fetch_err and go to ERR.
- Undefined: no counter is built, and WAIT waits indefinitely. fetch_err then reports misalignment only.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state enum (IDLE/REQ/WAIT/DONE/ERR);
  - the INSTR_BYTES=4 constant;
  - the reset-PC constant 32'h00000000, shared with the PC register.
- No sub-module needed. The optional timeout counter stays inline behind the macro.

Test Plan:
- Zero-latency memory: pc=0x00000010, fetch_start pulse, gnt=rvalid=1 on first REQ cycle, rdata=0x00A00093 → imem_addr=0x10, at cycle 2 ir=0x00A00093, ir_valid=1, pc_we=1, pc_next=0x14, then back to IDLE.
- Delayed handshake: gnt after 3 cycles, rvalid 2 cycles after gnt → imem_req stays high with addr stable for 3 cycles; DONE reached 6 cycles after start; exactly one pc_we pulse.
- Misaligned: pc=0x00000006, fetch_start → imem_req never asserted; fetch_err=1 next cycle; state ERR, busy=1 until rst low.
- Wrap: pc=0xFFFFFFFC fetch → pc_next=0x00000000.
- Reset mid-fetch: rst low while in WAIT, then rvalid arrives after release → all outputs zero; ir stays 0; no ir_valid.
- FETCH_TIMEOUT_EN, TIMEOUT=16: gnt given, rvalid never → fetch_err=1 after 16 cycles in WAIT; without the macro, busy stays high indefinitely.
